// File: rtl/imem_loader_pkg.sv
// imem_loader shared types: loader state encoding and field widths.
// Imported by the interface, the word packer and the loader top.
package imem_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        FINISH
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port.
// slave: loader side (accepts bytes, drives writes); master: host/memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    import imem_loader_pkg::*;

    logic                ByteValid;
    logic [7:0]          ByteData;
    logic                ByteReady;
    logic                IMemWE;
    logic [ADDR_W-1:0]   IMemAddr;
    logic [WORD_W-1:0]   IMemData;

    modport master (
        output ByteValid, ByteData,
        input  ByteReady, IMemWE, IMemAddr, IMemData
    );

    modport slave (
        input  ByteValid, ByteData,
        output ByteReady, IMemWE, IMemAddr, IMemData
    );

endinterface

// File: rtl/imem_word_packer.sv
// Assembles big-endian 32-bit words from bytes (first byte -> [31:24]).
// Ports: clk, rst_n (sync), clear, byte_en, byte_data -> word_valid, word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_en) begin
            shift_d = {shift_q[15:0], byte_data};
            idx_d   = idx_q + 2'd1;
        end
    end

    // Only three bytes need storing: the fourth is taken straight off
    // the bus in the cycle it is accepted.
    assign word_valid = byte_en && !clear && (idx_q == 2'd3);
    assign word       = {shift_q, byte_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory, holding the CPU in reset.
// Ports: Clk, Clrn, Load, bus (byte stream + imem write), CpuClrn, Busy, Done, Error.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic         Clk,
    input  logic         Clrn,
    input  logic         Load,
    imem_loader_if.slave bus,
    output logic         CpuClrn,
    output logic         Busy,
    output logic         Done,
    output logic         Error
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ovf_q, ovf_d;
    logic                we_q, we_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                ready;
    logic                xfer;
    logic                clear;
    logic                word_valid;
    logic [WORD_W-1:0]   word;

    assign ready = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
    assign xfer  = bus.ByteValid && ready;

    imem_word_packer u_packer (
        .clk       (Clk),
        .rst_n     (Clrn),
        .clear     (clear),
        .byte_en   (xfer && (state_q == DATA)),
        .byte_data (bus.ByteData),
        .word_valid(word_valid),
        .word      (word)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        clear   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Load) begin
                    state_d = LEN_HI;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    addr_d  = BASE;
                    ovf_d   = 1'b0;
                    clear   = 1'b1;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    rem_d[15:8] = bus.ByteData;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    rem_d[7:0] = bus.ByteData;
                    if ({rem_q[15:8], bus.ByteData} == '0) begin
                        state_d = FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // Write strobe and data are registered here so they
                // appear during the WRITE cycle itself.
                if (word_valid) begin
                    state_d = WRITE;
                    data_d  = word;
                    we_d    = !ovf_q;
                    err_d   = err_q || ovf_q;
                end
            end
            WRITE: begin
                rem_d = rem_q - 16'd1;
                if (rem_q == 16'd1) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = DATA;
                    // Past the top of memory the address parks and
                    // every further word is flagged instead of written.
                    if (&addr_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            state_q <= IDLE;
            rem_q   <= '0;
            addr_q  <= BASE;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.ByteReady = ready;
    assign bus.IMemWE    = we_q;
    assign bus.IMemAddr  = addr_q;
    assign bus.IMemData  = data_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign Error         = err_q;
    assign CpuClrn       = Clrn && !busy_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: dut0 (ADDR_W=10, BASE=0), dut1 (ADDR_W=2, BASE=2).
module tb_imem_loader;

    logic Clk = 1'b0;
    logic Clrn = 1'b0;
    logic load0 = 1'b0;
    logic load1 = 1'b0;
    logic cpu0, busy0, done0, err0;
    logic cpu1, busy1, done1, err1;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    imem_loader_if #(.ADDR_W(10)) bus0 ();
    imem_loader_if #(.ADDR_W(2))  bus1 ();

    imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut0 (
        .Clk(Clk), .Clrn(Clrn), .Load(load0), .bus(bus0),
        .CpuClrn(cpu0), .Busy(busy0), .Done(done0), .Error(err0)
    );

    imem_loader #(.ADDR_W(2), .BASE_ADDR(2)) dut1 (
        .Clk(Clk), .Clrn(Clrn), .Load(load1), .bus(bus1),
        .CpuClrn(cpu1), .Busy(busy1), .Done(done1), .Error(err1)
    );

    logic [9:0]  wa0[$];
    logic [31:0] wd0[$];
    logic [1:0]  wa1[$];
    logic [31:0] wd1[$];
    int dn0 = 0, dn1 = 0, dbad0 = 0, viol0 = 0, xf1 = 0;

    always @(posedge Clk) begin
        if (bus0.IMemWE) begin
            wa0.push_back(bus0.IMemAddr);
            wd0.push_back(bus0.IMemData);
        end
        if (bus1.IMemWE) begin
            wa1.push_back(bus1.IMemAddr);
            wd1.push_back(bus1.IMemData);
        end
        if (bus0.IMemWE && bus0.ByteReady) viol0++;
        if (done0) begin
            dn0++;
            if (cpu0 !== 1'b1) dbad0++;
        end
        if (done1) dn1++;
        if (bus1.ByteValid && bus1.ByteReady) xf1++;
    end

    logic [7:0] img[10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                            8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};

    task automatic pulse_load(input int d);
        if (d == 0) load0 = 1'b1; else load1 = 1'b1;
        @(posedge Clk); #1;
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic send(input int d, input logic [7:0] b);
        int n;
        logic rdy;
        if (d == 0) begin
            bus0.ByteValid = 1'b1; bus0.ByteData = b;
        end else begin
            bus1.ByteValid = 1'b1; bus1.ByteData = b;
        end
        n = 0;
        @(negedge Clk);
        rdy = (d == 0) ? bus0.ByteReady : bus1.ByteReady;
        while (rdy !== 1'b1 && n < 40) begin
            @(negedge Clk);
            n++;
            rdy = (d == 0) ? bus0.ByteReady : bus1.ByteReady;
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL send_ready dut%0d byte %h: ready=%b required 1", d, b, rdy);
        end
        @(posedge Clk); #1;
    endtask

    task automatic idle_gap(input int d, input int g);
        if (g > 0) begin
            if (d == 0) bus0.ByteValid = 1'b0; else bus1.ByteValid = 1'b0;
            repeat (g) @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset;
        Clrn = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++; if (bus0.ByteReady !== 1'b0) begin failures++; $display("FAIL rst_ready got %b req 0", bus0.ByteReady); end
        checks++; if (bus0.IMemWE !== 1'b0) begin failures++; $display("FAIL rst_we got %b req 0", bus0.IMemWE); end
        checks++; if (bus0.IMemAddr !== 10'd0) begin failures++; $display("FAIL rst_addr got %h req 0", bus0.IMemAddr); end
        checks++; if (bus0.IMemData !== 32'd0) begin failures++; $display("FAIL rst_data got %h req 0", bus0.IMemData); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rst_busy got %b req 0", busy0); end
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL rst_done got %b req 0", done0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL rst_error got %b req 0", err0); end
        checks++; if (cpu0 !== 1'b0) begin failures++; $display("FAIL rst_cpuclrn got %b req 0", cpu0); end
        checks++; if (bus1.IMemAddr !== 2'd2) begin failures++; $display("FAIL rst_addr_base got %h req 2", bus1.IMemAddr); end
        Clrn = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++; if (cpu0 !== 1'b1) begin failures++; $display("FAIL idle_cpuclrn got %b req 1", cpu0); end
        checks++; if (bus0.ByteReady !== 1'b0) begin failures++; $display("FAIL idle_ready got %b req 0", bus0.ByteReady); end
        @(posedge Clk); #1;
    endtask

    task automatic run_basic(input string nm, input int g[10]);
        int n0, d0, b0, v0, n;
        n0 = wa0.size(); d0 = dn0; b0 = dbad0; v0 = viol0;
        pulse_load(0);
        @(negedge Clk);
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL %s busy got %b req 1", nm, busy0); end
        checks++; if (cpu0 !== 1'b0) begin failures++; $display("FAIL %s cpu_held got %b req 0", nm, cpu0); end
        @(posedge Clk); #1;
        for (int i = 0; i < 10; i++) begin
            idle_gap(0, g[i]);
            send(0, img[i]);
        end
        bus0.ByteValid = 1'b0;
        n = 0;
        while (dn0 == d0 && n < 20) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        checks++; if (dn0 - d0 !== 1) begin failures++; $display("FAIL %s done_pulses got %0d req 1", nm, dn0 - d0); end
        checks++; if (dbad0 !== b0) begin failures++; $display("FAIL %s done_cpuclrn got %0d bad req 0", nm, dbad0 - b0); end
        checks++; if (viol0 !== v0) begin failures++; $display("FAIL %s ready_in_write got %0d req 0", nm, viol0 - v0); end
        checks++; if (wa0.size() - n0 !== 2) begin failures++; $display("FAIL %s writes got %0d req 2", nm, wa0.size() - n0); end
        if (wa0.size() - n0 >= 2) begin
            checks++; if (wa0[n0] !== 10'd0) begin failures++; $display("FAIL %s addr0 got %h req 0", nm, wa0[n0]); end
            checks++; if (wd0[n0] !== 32'h20080005) begin failures++; $display("FAIL %s data0 got %h req 20080005", nm, wd0[n0]); end
            checks++; if (wa0[n0+1] !== 10'd1) begin failures++; $display("FAIL %s addr1 got %h req 1", nm, wa0[n0+1]); end
            checks++; if (wd0[n0+1] !== 32'hAC010004) begin failures++; $display("FAIL %s data1 got %h req ac010004", nm, wd0[n0+1]); end
        end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL %s busy_after got %b req 0", nm, busy0); end
        checks++; if (err0 !== 1'b0) begin failures++; $display("FAIL %s error got %b req 0", nm, err0); end
        @(posedge Clk); #1;
    endtask

    task automatic test_basic;
        int gz[10] = '{default: 0};
        run_basic("basic", gz);
    endtask

    task automatic test_gaps;
        int gg[10] = '{2, 0, 5, 1, 3, 0, 4, 2, 0, 5};
        run_basic("gaps", gg);
    endtask

    task automatic test_zero_len;
        int n0;
        n0 = wa0.size();
        pulse_load(0);
        send(0, 8'h00);
        send(0, 8'h00);
        bus0.ByteValid = 1'b0;
        @(negedge Clk);
        checks++; if (done0 !== 1'b1) begin failures++; $display("FAIL zero_done got %b req 1", done0); end
        checks++; if (cpu0 !== 1'b1) begin failures++; $display("FAIL zero_cpuclrn got %b req 1", cpu0); end
        @(negedge Clk);
        checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL zero_done_end got %b req 0", done0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL zero_busy got %b req 0", busy0); end
        checks++; if (wa0.size() !== n0) begin failures++; $display("FAIL zero_writes got %0d req 0", wa0.size() - n0); end
        @(posedge Clk); #1;
    endtask

    task automatic test_overflow;
        logic [7:0] ov[14] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                               8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        int n0, d0, x0, n;
        n0 = wa1.size(); d0 = dn1; x0 = xf1;
        pulse_load(1);
        for (int i = 0; i < 14; i++) send(1, ov[i]);
        bus1.ByteValid = 1'b0;
        n = 0;
        while (dn1 == d0 && n < 20) begin @(negedge Clk); n++; end
        repeat (3) @(negedge Clk);
        checks++; if (dn1 - d0 !== 1) begin failures++; $display("FAIL ovf_done got %0d req 1", dn1 - d0); end
        checks++; if (xf1 - x0 !== 14) begin failures++; $display("FAIL ovf_consumed got %0d req 14", xf1 - x0); end
        checks++; if (wa1.size() - n0 !== 2) begin failures++; $display("FAIL ovf_writes got %0d req 2", wa1.size() - n0); end
        if (wa1.size() - n0 >= 2) begin
            checks++; if (wa1[n0] !== 2'd2) begin failures++; $display("FAIL ovf_addr0 got %h req 2", wa1[n0]); end
            checks++; if (wd1[n0] !== 32'h11223344) begin failures++; $display("FAIL ovf_data0 got %h req 11223344", wd1[n0]); end
            checks++; if (wa1[n0+1] !== 2'd3) begin failures++; $display("FAIL ovf_addr1 got %h req 3", wa1[n0+1]); end
            checks++; if (wd1[n0+1] !== 32'h55667788) begin failures++; $display("FAIL ovf_data1 got %h req 55667788", wd1[n0+1]); end
        end
        checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL ovf_error got %b req 1", err1); end
        checks++; if (bus1.IMemAddr !== 2'd3) begin failures++; $display("FAIL ovf_nowrap got %h req 3", bus1.IMemAddr); end
        repeat (4) @(negedge Clk);
        checks++; if (err1 !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b req 1", err1); end
        @(posedge Clk); #1;
    endtask

    task automatic test_mid_reset;
        logic [7:0] mr[7] = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12};
        int gz[10] = '{default: 0};
        int n0;
        n0 = wa0.size();
        pulse_load(0);
        for (int i = 0; i < 7; i++) send(0, mr[i]);
        bus0.ByteValid = 1'b0;
        Clrn = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL mid_busy got %b req 0", busy0); end
        checks++; if (bus0.ByteReady !== 1'b0) begin failures++; $display("FAIL mid_ready got %b req 0", bus0.ByteReady); end
        checks++; if (bus0.IMemAddr !== 10'd0) begin failures++; $display("FAIL mid_addr got %h req 0", bus0.IMemAddr); end
        checks++; if (wa0.size() - n0 !== 1) begin failures++; $display("FAIL mid_writes got %0d req 1", wa0.size() - n0); end
        if (wa0.size() - n0 >= 1) begin
            checks++; if (wd0[n0] !== 32'hDEADBEEF) begin failures++; $display("FAIL mid_data got %h req deadbeef", wd0[n0]); end
        end
        Clrn = 1'b1;
        @(posedge Clk); #1;
        run_basic("restart", gz);
    endtask

    initial begin
        bus0.ByteValid = 1'b0; bus0.ByteData = 8'h00;
        bus1.ByteValid = 1'b0; bus1.ByteData = 8'h00;
        test_reset();
        test_basic();
        test_zero_len();
        test_gaps();
        test_overflow();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
